loop_seq_2lvl: RTL and testbench
================================

Name: loop_seq_2lvl

Overview:
Two-level loop sequencer that drives a loop-counter interface. It issues per-iteration enables and consumes the wrap ("over") condition, rather than counting on request.
- Generates (outer, inner) index pairs for nested MFCC loops, e.g. frame × filter-bin or filter × coefficient.
- Presents each pair to a downstream datapath through a valid/ready handshake.
- Reports start/busy/done to the top-level controller.

Parameters:
CNT_W, 7, width of each loop index and limit
OUTER_EN, 1, 1 = two-level nesting; 0 = outer loop disabled (outer_value ignored, treated as 0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
start  in  1  1-cycle request to begin a sequence; sampled only in IDLE
inner_value  in  CNT_W  inclusive inner limit (inner index runs 0..inner_value); latched at start
outer_value  in  CNT_W  inclusive outer limit (outer index runs 0..outer_value); latched at start
step_ready  in  1  downstream accepts the current index pair
step_valid  out  1  current index pair is valid
inner_idx  out  CNT_W  current inner index
outer_idx  out  CNT_W  current outer index
inner_last  out  1  inner_idx == latched inner limit (the "over" flag)
outer_last  out  1  outer_idx == latched outer limit
busy  out  1  high in RUN
done  out  1  1-cycle pulse after the final pair is accepted

Behaviour:
- FSM states:
  - IDLE: busy=0, step_valid=0.
  - RUN: busy=1, step_valid=1.
  - DONE: busy=0, step_valid=0, done=1 for exactly one cycle, then IDLE.
- Reset: when rst=1 at a rising edge, go to IDLE. Indices, latched limits, step_valid, busy and done all become 0. This applies in any state, mid-sequence included; no done is emitted and the sequence is abandoned.
- IDLE → RUN on start=1:
  - Latch inner_value and outer_value (outer forced to 0 when OUTER_EN=0).
  - Clear both indices.
  - step_valid rises on the cycle after start, giving 1-cycle latency from start to the first pair.
- start while in RUN or DONE: ignored; limits are not re-latched.
- Input changes to inner_value/outer_value after the latch have no effect until the next start.
- Handshake:
  - A transfer occurs when step_valid && step_ready at a rising edge.
  - Without a transfer, the outputs hold stable.
  - step_valid never drops in RUN without a transfer.
- On a transfer in RUN:
  - inner_last=0: inner_idx+1.
  - inner_last=1, outer_last=0: inner_idx→0, outer_idx+1.
  - inner_last=1, outer_last=1: go to DONE. Indices hold their final values for one cycle, then clear to 0 on entering IDLE.
- Sequence length is exactly (inner_value+1)*(outer_value+1) transfers, in row-major order (inner fastest).
- Back-to-back throughput: 1 pair per cycle with step_ready held high.
- Boundary cases:
  - inner_value=outer_value=0: exactly one transfer, then done.
  - Limit 2^CNT_W-1 (127): the index reaches 127 and wraps to 0 via the last condition, never via natural overflow. Adders are CNT_W bits and the carry is discarded.
  - inner_last and outer_last are combinational compares on registered indices against the latched limits. Both are 0 outside RUN.
- start in the DONE cycle is ignored. The earliest restart is a start in the following IDLE cycle.
- All outputs are registered except inner_last/outer_last (compare outputs) and step_valid/busy (decoded from the state register).

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - CNT_W default constant.
- One sub-module instantiated twice (inner and outer): loop_idx_cnt. It is a synchronous, active-high-reset wrapping index counter with inputs clr, en, limit, and outputs idx and last. On en, it wraps to 0 when last=1. clr has priority over en.

Test Plan:
- Reset mid-sequence: inner=3, outer=2, start, 5 transfers, assert rst for 1 cycle → next cycle IDLE, idx=0/0, step_valid=0, busy=0, no done pulse. A fresh start then begins at (0,0).
- Basic nesting: inner=2, outer=1, step_ready=1 → pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) on 6 consecutive cycles. done pulses 1 cycle after the 6th; busy falls together with done.
- Backpressure: inner=3, outer=0, step_ready toggles 1,0,0,1,... → indices hold while ready=0. Exactly 4 transfers 0..3, done once, no skipped or duplicated pair.
- Degenerate and maximum: inner=0, outer=0 → 1 transfer then done. inner=127, outer=1 → 256 transfers; inner_idx goes 127→0 with outer 0→1; done after the final (1,127).
- Start/limit hygiene: start held high for 3 cycles in RUN, and inner_value changed from 2 to 9 after the latch → single sequence using limit 2 (3 pairs when outer=0); no restart while busy.
- OUTER_EN=0: outer_value=5, inner=1 → only (0,0),(0,1); outer_idx stays 0; outer_last=1 throughout RUN.

Source files
------------

// File: rtl/loop_seq_2lvl_pkg.sv
// Shared definitions for the two-level loop sequencer: state encoding and default index width.
package loop_seq_2lvl_pkg;

  localparam int unsigned CNT_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/loop_idx_cnt.sv
// Wrapping loop index counter: counts up on en and returns to 0 after reaching the limit.
module loop_idx_cnt
  import loop_seq_2lvl_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] idx,
  output logic         last
);

  assign last = (idx == limit);

  // clr wins over en; wrap comes from last, never from adder overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : W'(idx + W'(1));
    end
  end

endmodule

// File: rtl/loop_seq_2lvl.sv
// Two-level loop sequencer: streams (outer, inner) index pairs over valid/ready, inner fastest.
module loop_seq_2lvl
  import loop_seq_2lvl_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned OUTER_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] inner_value,
  input  logic [CNT_W-1:0] outer_value,
  input  logic             step_ready,
  output logic             step_valid,
  output logic [CNT_W-1:0] inner_idx,
  output logic [CNT_W-1:0] outer_idx,
  output logic             inner_last,
  output logic             outer_last,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] inner_lim_q;
  logic [CNT_W-1:0] outer_lim_q;
  logic             in_last_raw;
  logic             out_last_raw;
  logic             run;
  logic             start_acc;
  logic             xfer;
  logic             final_xfer;
  logic             idx_clr;
  logic             inner_en;
  logic             outer_en;

  assign run        = (state_q == ST_RUN);
  assign start_acc  = (state_q == ST_IDLE) && start;
  assign xfer       = run && step_ready;
  assign final_xfer = xfer && in_last_raw && out_last_raw;

  // Indices hold their final values through DONE, then clear on the way back to IDLE
  assign idx_clr  = start_acc || (state_q == ST_DONE);
  assign inner_en = xfer && !final_xfer;
  assign outer_en = xfer && in_last_raw && !out_last_raw;

  assign step_valid = run;
  assign busy       = run;
  assign inner_last = run && in_last_raw;
  assign outer_last = run && out_last_raw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)      state_d = ST_RUN;
      ST_RUN:  if (final_xfer) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_d == ST_DONE);
    end
  end

  // Limits are captured only when a sequence is launched
  always_ff @(posedge clk) begin
    if (rst) begin
      inner_lim_q <= '0;
      outer_lim_q <= '0;
    end else if (start_acc) begin
      inner_lim_q <= inner_value;
      outer_lim_q <= (OUTER_EN != 0) ? outer_value : '0;
    end
  end

  loop_idx_cnt #(.W(CNT_W)) u_inner (
    .clk   (clk),
    .rst   (rst),
    .clr   (idx_clr),
    .en    (inner_en),
    .limit (inner_lim_q),
    .idx   (inner_idx),
    .last  (in_last_raw)
  );

  loop_idx_cnt #(.W(CNT_W)) u_outer (
    .clk   (clk),
    .rst   (rst),
    .clr   (idx_clr),
    .en    (outer_en),
    .limit (outer_lim_q),
    .idx   (outer_idx),
    .last  (out_last_raw)
  );

endmodule

// File: tb/tb_loop_seq_2lvl.sv
// Bench for loop_seq_2lvl: nested-loop reference sequence versus DUT under random/directed ready.
module tb_loop_seq_2lvl;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [W-1:0] in_v;
  logic [W-1:0] out_v;
  bit           sel;

  int total = 0;
  int bad   = 0;

  logic         start0, start1, ready0, ready1;
  logic         v0, il0, ol0, b0, d0;
  logic         v1, il1, ol1, b1, d1;
  logic [W-1:0] ii0, oi0, ii1, oi1;
  logic         v, il, ol, b, d;
  logic [W-1:0] ii, oi;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign ready0 = ready & ~sel;
  assign ready1 = ready & sel;

  always_comb begin
    v  = sel ? v1  : v0;
    il = sel ? il1 : il0;
    ol = sel ? ol1 : ol0;
    b  = sel ? b1  : b0;
    d  = sel ? d1  : d0;
    ii = sel ? ii1 : ii0;
    oi = sel ? oi1 : oi0;
  end

  loop_seq_2lvl #(.CNT_W(W), .OUTER_EN(1)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .inner_value(in_v), .outer_value(out_v),
    .step_ready(ready0), .step_valid(v0), .inner_idx(ii0), .outer_idx(oi0),
    .inner_last(il0), .outer_last(ol0), .busy(b0), .done(d0)
  );

  loop_seq_2lvl #(.CNT_W(W), .OUTER_EN(0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .inner_value(in_v), .outer_value(out_v),
    .step_ready(ready1), .step_valid(v1), .inner_idx(ii1), .outer_idx(oi1),
    .inner_last(il1), .outer_last(ol1), .busy(b1), .done(d1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, v, 0);
    chk({tag, "_busy"}, b, 0);
    chk({tag, "_done"}, d, 0);
    chk({tag, "_inner_idx"}, ii, 0);
    chk({tag, "_outer_idx"}, oi, 0);
    chk({tag, "_inner_last"}, il, 0);
    chk({tag, "_outer_last"}, ol, 0);
  endtask

  // rmode: 0 = ready always high, 1 = random ready, 2 = ready pattern 1,0,0 repeating
  task automatic run_seq(input int il_, input int ol_, input int rmode, input bit hygiene);
    int exp_i[$];
    int exp_o[$];
    int eo;
    int k;
    int budget;
    int last_i;
    int last_o;
    eo = sel ? 0 : ol_;
    for (int o = 0; o <= eo; o++)
      for (int i = 0; i <= il_; i++) begin
        exp_i.push_back(i);
        exp_o.push_back(o);
      end
    last_i = 0;
    last_o = 0;
    @(negedge clk);
    in_v  = W'(il_);
    out_v = W'(ol_);
    start = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    if (!hygiene) start = 1'b0;
    in_v  = W'(il_ + 7);
    out_v = W'($urandom);
    chk("first_valid", v, 1);
    k = 0;
    budget = exp_i.size() * 4 + 20;
    while (exp_i.size() > 0 && k < budget) begin
      if (k > 0) @(negedge clk);
      if (hygiene && k >= 3) start = 1'b0;
      chk("run_valid", v, 1);
      chk("run_busy", b, 1);
      chk("run_done", d, 0);
      chk("inner_idx", ii, exp_i[0]);
      chk("outer_idx", oi, exp_o[0]);
      chk("inner_last", il, 32'(exp_i[0] == il_));
      chk("outer_last", ol, 32'(exp_o[0] == eo));
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (k % 3 == 0);
      endcase
      if (v && ready) begin
        last_i = exp_i.pop_front();
        last_o = exp_o.pop_front();
      end
      k++;
    end
    if (exp_i.size() > 0) chk("timeout_pairs_left", exp_i.size(), 0);
    @(negedge clk);
    ready = 1'b0;
    start = 1'b0;
    chk("done_pulse", d, 1);
    chk("done_busy", b, 0);
    chk("done_valid", v, 0);
    chk("done_inner_hold", ii, last_i);
    chk("done_outer_hold", oi, last_o);
    chk("done_inner_last", il, 0);
    chk("done_outer_last", ol, 0);
    @(negedge clk);
    check_idle("after_done");
  endtask

  initial begin
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    in_v  = '0;
    out_v = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");

    // Reset abandons a running sequence
    in_v  = W'(3);
    out_v = W'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_inner_idx", ii, 1);
    chk("mid_outer_idx", oi, 1);
    rst   = 1'b1;
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    @(negedge clk);
    check_idle("mid_reset_no_done");
    run_seq(3, 2, 1, 1'b0);

    run_seq(2, 1, 0, 1'b0);
    run_seq(3, 0, 2, 1'b0);
    run_seq(0, 0, 1, 1'b0);
    run_seq(127, 1, 1, 1'b0);
    run_seq(2, 0, 0, 1'b1);
    for (int r = 0; r < 4; r++)
      run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b0);

    sel = 1'b1;
    @(negedge clk);
    check_idle("outer_dis_idle");
    run_seq(1, 5, 0, 1'b0);
    run_seq(int'($urandom_range(0, 5)), int'($urandom_range(1, 9)), 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
